// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two requesters (fetch I, data D), the arbiter and
// the single-ported memory. The arbiter connects to the slave modport.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_gnt;
  logic          i_rvalid;
  logic [DW-1:0] i_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          mem_ren;
  logic          mem_wen;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;
  logic          err_addr;
  logic [31:0]   acc_count;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_dout,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           mem_ren, mem_wen, mem_addr, mem_din, err_addr, acc_count
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_dout,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           mem_ren, mem_wen, mem_addr, mem_din, err_addr, acc_count
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between instruction
// fetch (read-only) and data access (read/write). One access per cycle;
// request sampled at edge N -> gnt cycle N+1 -> rvalid cycle N+2.
module mem_port_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MEM_BITS = 10
) (
  input  logic             clock,
  input  logic             reset,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACC_I, ACC_D} state_t;

  state_t        r_state, w_next;
  logic          r_pref_d;        // 1: D wins a tie, 0: I wins a tie
  logic [AW-1:0] r_addr;
  logic          r_we;
  logic [DW-1:0] r_wdata;
  logic          r_i_rvalid, r_d_rvalid;
  logic [DW-1:0] r_i_rdata, r_d_rdata;
  logic          r_err;
  logic [31:0]   r_count;
  logic          w_i_gnt, w_d_gnt, w_ren, w_wen;
  logic [AW-1:0] w_new_addr;

  // State register
  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Arbitration (evaluated in every state) and memory bus strobes
  always_comb begin
    w_next  = IDLE;
    w_i_gnt = 1'b0;
    w_d_gnt = 1'b0;
    w_ren   = 1'b0;
    w_wen   = 1'b0;
    if (bus.i_req && (!bus.d_req || !r_pref_d)) w_next = ACC_I;
    else if (bus.d_req)                         w_next = ACC_D;
    case (r_state)
      ACC_I: begin
        w_i_gnt = 1'b1;
        w_ren   = 1'b1;
      end
      ACC_D: begin
        w_d_gnt = 1'b1;
        w_ren   = !r_we;
        w_wen   = r_we;
      end
      default: ;
    endcase
  end

  assign w_new_addr = (w_next == ACC_D) ? bus.d_addr : bus.i_addr;

  // Round-robin pointer: the requester just granted loses the next tie
  always_ff @(posedge clock) begin
    if (reset)                 r_pref_d <= 1'b1;
    else if (w_next == ACC_I)  r_pref_d <= 1'b1;
    else if (w_next == ACC_D)  r_pref_d <= 1'b0;
  end

  // Latch the granted request so the requester is free to move on
  always_ff @(posedge clock) begin
    if (reset) begin
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
    end else if (w_next == ACC_I) begin
      r_addr  <= bus.i_addr;
      r_we    <= 1'b0;
    end else if (w_next == ACC_D) begin
      r_addr  <= bus.d_addr;
      r_we    <= bus.d_we;
      r_wdata <= bus.d_wdata;
    end
  end

  // Sticky out-of-range flag; the access itself still runs on the low bits
  always_ff @(posedge clock) begin
    if (reset) r_err <= 1'b0;
    else if (w_next != IDLE && |w_new_addr[AW-1:MEM_BITS]) r_err <= 1'b1;
  end

  // Completion: capture read data, pulse rvalid, count the access
  always_ff @(posedge clock) begin
    if (reset) begin
      r_i_rvalid <= 1'b0;
      r_d_rvalid <= 1'b0;
      r_i_rdata  <= '0;
      r_d_rdata  <= '0;
      r_count    <= '0;
    end else begin
      r_i_rvalid <= (r_state == ACC_I);
      r_d_rvalid <= (r_state == ACC_D);
      if (r_state == ACC_I)          r_i_rdata <= bus.mem_dout;
      if (r_state == ACC_D && !r_we) r_d_rdata <= bus.mem_dout;
      if (r_state != IDLE)           r_count   <= r_count + 32'd1;
    end
  end

  assign bus.i_gnt     = w_i_gnt;
  assign bus.d_gnt     = w_d_gnt;
  assign bus.mem_ren   = w_ren;
  assign bus.mem_wen   = w_wen;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_din   = r_wdata;
  assign bus.i_rvalid  = r_i_rvalid;
  assign bus.i_rdata   = r_i_rdata;
  assign bus.d_rvalid  = r_d_rvalid;
  assign bus.d_rdata   = r_d_rdata;
  assign bus.err_addr  = r_err;
  assign bus.acc_count = r_count;
endmodule
